// File: rtl/ctrl_bubble_pipe_if.sv
// Control-pipeline handshake bundle: decoded control word in, per-stage words/valids and
// upstream stall out. The master side is the hazard unit / decoder, the slave side the pipe.
interface ctrl_bubble_pipe_if #(
  parameter int unsigned CTRL_W = 13,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned LEN_W  = 3
);
  logic [CTRL_W-1:0]       ctrl_in;
  logic                    valid_in;
  logic                    hold_i;
  logic [DEPTH-1:0]        flush_i;
  logic                    bub_req_i;
  logic [LEN_W-1:0]        bub_len_i;
  logic [DEPTH*CTRL_W-1:0] ctrl_out;
  logic [DEPTH-1:0]        vld_out;
  logic                    stall_up_o;

  modport master (
    output ctrl_in, valid_in, hold_i, flush_i, bub_req_i, bub_len_i,
    input  ctrl_out, vld_out, stall_up_o
  );

  modport slave (
    input  ctrl_in, valid_in, hold_i, flush_i, bub_req_i, bub_len_i,
    output ctrl_out, vld_out, stall_up_o
  );
endinterface

// File: rtl/ctrl_bubble_pipe.sv
// Control-word pipeline (ID/EX onward) with per-stage flush, global hold and multi-cycle bubble
// insertion. Define CTRL_PIPE_PERF_EN to build the saturating bubble-cycle counter.
module ctrl_bubble_pipe #(
  parameter int unsigned CTRL_W = 13,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned LEN_W  = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ctrl_bubble_pipe_if.slave    bus,
  input  logic                 perf_clr_i,
  output logic [CNT_W-1:0]     bub_cnt_o
);

  typedef enum logic {StIdle, StInsert} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               len_nz;
  logic               idle_req;
  logic               insert_bub;

  logic [CTRL_W-1:0]  word_q [DEPTH];
  logic [DEPTH-1:0]   vld_q;

  assign len_nz   = |bus.bub_len_i;
  assign idle_req = (state_q == StIdle) && bus.bub_req_i && len_nz;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // FSM next state; a stage-0 flush cancels any sequence and wins over a same-cycle request
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (bus.flush_i[0]) begin
      state_d = StIdle;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (idle_req && !bus.hold_i && (bus.bub_len_i != LEN_W'(1))) begin
            state_d = StInsert;
            rem_d   = bus.bub_len_i - LEN_W'(1);
          end
        end
        StInsert: begin
          if (!bus.hold_i) begin
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
          rem_d   = '0;
        end
      endcase
    end
  end

  // FSM outputs; stall ignores hold since the upstream ORs hold in on its own
  always_comb begin
    bus.stall_up_o = (state_q == StInsert) || (idle_req && !bus.flush_i[0]);
    insert_bub     = !bus.hold_i && ((state_q == StInsert) || idle_req);
  end

  // Stage 0: flush > hold > bubble > new word (invalid words are forced to zero)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q[0] <= '0;
      vld_q[0]  <= 1'b0;
    end else if (bus.flush_i[0]) begin
      word_q[0] <= '0;
      vld_q[0]  <= 1'b0;
    end else if (!bus.hold_i) begin
      if (insert_bub) begin
        word_q[0] <= '0;
        vld_q[0]  <= 1'b0;
      end else begin
        word_q[0] <= bus.valid_in ? bus.ctrl_in : '0;
        vld_q[0]  <= bus.valid_in;
      end
    end
  end

  // Downstream stages take the pre-edge content of the stage above, even if that one is flushed
  for (genvar k = 1; k < DEPTH; k++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q[k] <= '0;
        vld_q[k]  <= 1'b0;
      end else if (bus.flush_i[k]) begin
        word_q[k] <= '0;
        vld_q[k]  <= 1'b0;
      end else if (!bus.hold_i) begin
        word_q[k] <= word_q[k-1];
        vld_q[k]  <= vld_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_out
    assign bus.ctrl_out[k*CTRL_W +: CTRL_W] = word_q[k];
  end
  assign bus.vld_out = vld_q;

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (perf_clr_i) begin
      cnt_q <= '0;
    end else if (insert_bub && !bus.flush_i[0] && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bub_cnt_o = cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign bub_cnt_o       = '0;
`endif

endmodule

// File: tb/tb_ctrl_bubble_pipe.sv
// Directed bench for ctrl_bubble_pipe: pass-through, bubbles, hold, flush, reset and perf counter.
module tb_ctrl_bubble_pipe;
  localparam int unsigned CW  = 13;
  localparam int unsigned D   = 3;
  localparam int unsigned LW  = 3;
  localparam int unsigned CNW = 4;
`ifdef CTRL_PIPE_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           perf_clr;
  logic [CNW-1:0] bub_cnt;
  int             checks = 0;
  int             errors = 0;

  ctrl_bubble_pipe_if #(.CTRL_W(CW), .DEPTH(D), .LEN_W(LW)) bus ();

  ctrl_bubble_pipe #(.CTRL_W(CW), .DEPTH(D), .LEN_W(LW), .CNT_W(CNW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .perf_clr_i (perf_clr),
    .bub_cnt_o  (bub_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] stg(input int k);
    return bus.ctrl_out[k*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ctrl_in   = '0;
    bus.valid_in  = 1'b0;
    bus.hold_i    = 1'b0;
    bus.flush_i   = '0;
    bus.bub_req_i = 1'b0;
    bus.bub_len_i = '0;
    perf_clr      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.valid_in = 1'b1;
    bus.ctrl_in  = 13'h1FF;
    step();
    checks++; if (bus.vld_out !== 3'b000) begin errors++; $display("FAIL reset_vld: got %b expected %b", bus.vld_out, 3'b000); end
    checks++; if (bus.ctrl_out !== '0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", bus.ctrl_out); end
    checks++; if (bus.stall_up_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_up_o); end
    checks++; if (bub_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bub_cnt); end
    clear_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_pass_through();
    bus.valid_in = 1'b1;
    bus.ctrl_in  = 13'h1A5;
    step();
    checks++; if (bus.vld_out !== 3'b001) begin errors++; $display("FAIL pass_vld1: got %b expected %b", bus.vld_out, 3'b001); end
    checks++; if (stg(0) !== 13'h1A5) begin errors++; $display("FAIL pass_s0: got %h expected %h", stg(0), 13'h1A5); end
    bus.valid_in = 1'b0;
    bus.ctrl_in  = 13'h1FFF;  // invalid word must still enter as zero
    step();
    checks++; if (bus.vld_out !== 3'b010) begin errors++; $display("FAIL pass_vld2: got %b expected %b", bus.vld_out, 3'b010); end
    checks++; if (bus.ctrl_out !== {13'h000, 13'h1A5, 13'h000}) begin errors++; $display("FAIL pass_ctrl2: got %h expected %h", bus.ctrl_out, {13'h000, 13'h1A5, 13'h000}); end
    step();
    checks++; if (bus.vld_out !== 3'b100) begin errors++; $display("FAIL pass_vld3: got %b expected %b", bus.vld_out, 3'b100); end
    checks++; if (bus.ctrl_out !== {13'h1A5, 13'h000, 13'h000}) begin errors++; $display("FAIL pass_ctrl3: got %h expected %h", bus.ctrl_out, {13'h1A5, 13'h000, 13'h000}); end
    clear_inputs();
    step();
  endtask

  task automatic test_bubble2();
    bus.valid_in = 1'b1;
    bus.ctrl_in  = 13'h0AA;
    step();
    bus.ctrl_in   = 13'h155;
    bus.bub_req_i = 1'b1;
    bus.bub_len_i = 3'd2;
    #1;
    checks++; if (bus.stall_up_o !== 1'b1) begin errors++; $display("FAIL bub2_stall_c0: got %b expected 1", bus.stall_up_o); end
    step();
    bus.bub_req_i = 1'b0;
    #1;
    checks++; if (bus.stall_up_o !== 1'b1) begin errors++; $display("FAIL bub2_stall_c1: got %b expected 1", bus.stall_up_o); end
    checks++; if (bus.ctrl_out[2*CW-1:0] !== {13'h0AA, 13'h000}) begin errors++; $display("FAIL bub2_e1: got %h expected %h", bus.ctrl_out[2*CW-1:0], {13'h0AA, 13'h000}); end
    checks++; if (bus.vld_out[1:0] !== 2'b10) begin errors++; $display("FAIL bub2_vld_e1: got %b expected 10", bus.vld_out[1:0]); end
    step();
    checks++; if (bus.stall_up_o !== 1'b0) begin errors++; $display("FAIL bub2_stall_c2: got %b expected 0", bus.stall_up_o); end
    checks++; if (bus.vld_out !== 3'b100) begin errors++; $display("FAIL bub2_vld_e2: got %b expected 100", bus.vld_out); end
    checks++; if (stg(2) !== 13'h0AA) begin errors++; $display("FAIL bub2_s2: got %h expected %h", stg(2), 13'h0AA); end
    step();
    checks++; if (bus.vld_out !== 3'b001 || stg(0) !== 13'h155) begin errors++; $display("FAIL bub2_resume: got vld %b s0 %h expected 001 155", bus.vld_out, stg(0)); end
    clear_inputs();
  endtask

  task automatic test_hold_insert();
    int stalls = 0;
    bus.flush_i = 3'b111;
    step();
    bus.flush_i  = '0;
    bus.valid_in = 1'b1;
    bus.ctrl_in  = 13'h0F0;
    step();
    bus.ctrl_in   = 13'h123;
    bus.bub_req_i = 1'b1;
    bus.bub_len_i = 3'd3;
    #1; stalls += int'(bus.stall_up_o);
    step();
    bus.bub_req_i = 1'b0;
    bus.hold_i    = 1'b1;
    #1; stalls += int'(bus.stall_up_o);
    step();
    #1; stalls += int'(bus.stall_up_o);
    checks++; if (bus.vld_out !== 3'b010 || stg(1) !== 13'h0F0) begin errors++; $display("FAIL hold_frozen: got vld %b s1 %h expected 010 0f0", bus.vld_out, stg(1)); end
    step();
    bus.hold_i = 1'b0;
    #1; stalls += int'(bus.stall_up_o);
    step();
    checks++; if (bus.vld_out !== 3'b100 || stg(2) !== 13'h0F0) begin errors++; $display("FAIL hold_after: got vld %b s2 %h expected 100 0f0", bus.vld_out, stg(2)); end
    #1; stalls += int'(bus.stall_up_o);
    step();
    #1; stalls += int'(bus.stall_up_o);
    checks++; if (bus.vld_out !== 3'b000) begin errors++; $display("FAIL hold_three_bubbles: got %b expected 000", bus.vld_out); end
    step();
    checks++; if (bus.vld_out !== 3'b001 || stg(0) !== 13'h123) begin errors++; $display("FAIL hold_resume: got vld %b s0 %h expected 001 123", bus.vld_out, stg(0)); end
    checks++; if (stalls !== 5) begin errors++; $display("FAIL hold_stall_cycles: got %0d expected 5", stalls); end
    clear_inputs();
  endtask

  task automatic test_flush();
    bus.bub_req_i = 1'b1;
    bus.bub_len_i = 3'd3;
    step();
    bus.bub_req_i = 1'b0;
    bus.flush_i   = 3'b001;
    step();
    bus.flush_i  = '0;
    bus.valid_in = 1'b1;
    bus.ctrl_in  = 13'h0C3;
    #1;
    checks++; if (bus.stall_up_o !== 1'b0) begin errors++; $display("FAIL flush_fsm_idle: got %b expected 0", bus.stall_up_o); end
    step();
    checks++; if (bus.vld_out[0] !== 1'b1 || stg(0) !== 13'h0C3) begin errors++; $display("FAIL flush_no_bubble: got vld0 %b s0 %h expected 1 0c3", bus.vld_out[0], stg(0)); end
    bus.ctrl_in = 13'h03C;
    step();
    bus.flush_i = 3'b010;
    bus.ctrl_in = 13'h111;
    step();
    checks++; if (bus.ctrl_out !== {13'h0C3, 13'h000, 13'h111}) begin errors++; $display("FAIL flush_s1_only: got %h expected %h", bus.ctrl_out, {13'h0C3, 13'h000, 13'h111}); end
    checks++; if (bus.vld_out !== 3'b101) begin errors++; $display("FAIL flush_s1_vld: got %b expected 101", bus.vld_out); end
    // flush of stage 0 beats a same-cycle request from IDLE
    bus.flush_i   = 3'b001;
    bus.valid_in  = 1'b0;
    bus.bub_req_i = 1'b1;
    bus.bub_len_i = 3'd2;
    #1;
    checks++; if (bus.stall_up_o !== 1'b0) begin errors++; $display("FAIL flush_req_stall: got %b expected 0", bus.stall_up_o); end
    step();
    clear_inputs();
    #1;
    checks++; if (bus.stall_up_o !== 1'b0) begin errors++; $display("FAIL flush_req_ignored: got %b expected 0", bus.stall_up_o); end
  endtask

  task automatic test_reset_mid();
    bus.valid_in = 1'b1;
    bus.ctrl_in  = 13'h0AB;
    step();
    bus.valid_in  = 1'b0;
    bus.bub_req_i = 1'b1;
    bus.bub_len_i = 3'd4;
    step();
    bus.bub_req_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.ctrl_out !== '0 || bus.vld_out !== 3'b000) begin errors++; $display("FAIL rstmid_outputs: got ctrl %h vld %b expected 0 000", bus.ctrl_out, bus.vld_out); end
    checks++; if (bus.stall_up_o !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", bus.stall_up_o); end
    #2 rst_n = 1'b1;
    bus.valid_in = 1'b1;
    bus.ctrl_in  = 13'h1A5;
    step();
    bus.valid_in = 1'b0;
    #1;
    checks++; if (bus.vld_out !== 3'b001 || stg(0) !== 13'h1A5) begin errors++; $display("FAIL rstmid_resume: got vld %b s0 %h expected 001 1a5", bus.vld_out, stg(0)); end
    checks++; if (bus.stall_up_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_leftover: got %b expected 0", bus.stall_up_o); end
    clear_inputs();
    step();
  endtask

  task automatic test_perf();
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    checks++; if (bub_cnt !== 4'd0) begin errors++; $display("FAIL perf_clr0: got %0d expected 0", bub_cnt); end
    bus.bub_req_i = 1'b1;
    bus.bub_len_i = 3'd1;
    repeat (3) step();
    checks++; if (bub_cnt !== (PerfEn ? 4'd3 : 4'd0)) begin errors++; $display("FAIL perf_three: got %0d expected %0d", bub_cnt, PerfEn ? 3 : 0); end
    bus.hold_i = 1'b1;
    step();
    checks++; if (bub_cnt !== (PerfEn ? 4'd3 : 4'd0)) begin errors++; $display("FAIL perf_held: got %0d expected %0d", bub_cnt, PerfEn ? 3 : 0); end
    bus.hold_i = 1'b0;
    repeat (17) step();
    checks++; if (bub_cnt !== (PerfEn ? 4'd15 : 4'd0)) begin errors++; $display("FAIL perf_saturate: got %0d expected %0d", bub_cnt, PerfEn ? 15 : 0); end
    perf_clr = 1'b1;
    step();
    checks++; if (bub_cnt !== 4'd0) begin errors++; $display("FAIL perf_clr_prio: got %0d expected 0", bub_cnt); end
    clear_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_bubble2();
    test_hold_insert();
    test_flush();
    test_reset_mid();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
